// File: rtl/bf_exec_sequencer.sv
// +--------------------------------------------------------------------------+
// | bf_exec_sequencer: steps bf_command_runner over one shared sync RAM      |
// | (fetch, cell read, run pulse, write-back, output, halt, end-of-program). |
// | Optional single-step mode: define BF_SINGLE_STEP_EN (adds step_req).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bf_exec_sequencer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] PROG_BASE  = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] TAPE_BASE  = 16'h8000,
    parameter logic [ADDR_WIDTH-1:0] PROG_LEN   = 16'h4000
) (
    input  logic                  clk,
    input  logic                  reset_trigger,
    input  logic                  start,
`ifdef BF_SINGLE_STEP_EN
    input  logic                  step_req,
`endif
    output logic                  done,
    output logic                  busy,
    output logic [31:0]           instr_count,
    output logic                  run_trigger,
    output logic [2:0]            current_command,
    output logic [7:0]            current_value,
    input  logic [ADDR_WIDTH-1:0] command_addr,
    input  logic [ADDR_WIDTH-1:0] cell_addr,
    input  logic [7:0]            new_value,
    input  logic                  write_trigger,
    input  logic                  search_active,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_FWAIT = 4'd2,
        S_CELL  = 4'd3,
        S_CWAIT = 4'd4,
        S_RUN   = 4'd5,
        S_POST  = 4'd6,
        S_OUT   = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam logic [2:0] c_cmd_out  = 3'b110;
    localparam logic [2:0] c_cmd_halt = 3'b111;

    state_t                state_q;
    logic [2:0]            command_q;
    logic [7:0]            value_q;
    logic                  run_q;
    logic [31:0]           count_q;
    logic                  out_pend_q;
    logic                  out_valid_q;
    logic [7:0]            out_data_q;

    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [ADDR_WIDTH-1:0] tape_addr;
    logic                  past_end;
    logic                  go_idle;
    state_t                step_exit;

    assign prog_addr = PROG_BASE + command_addr;
    assign tape_addr = TAPE_BASE + cell_addr;
    assign past_end  = (command_addr >= PROG_LEN);

`ifdef BF_SINGLE_STEP_EN
    assign go_idle   = start | step_req;
    assign step_exit = S_IDLE;
`else
    assign go_idle   = start;
    assign step_exit = S_FETCH;
`endif

    always_ff @(posedge clk or posedge reset_trigger) begin
        if (reset_trigger) begin
            state_q     <= S_IDLE;
            command_q   <= 3'd0;
            value_q     <= 8'd0;
            run_q       <= 1'b0;
            count_q     <= 32'd0;
            out_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go_idle) begin
                        state_q <= S_FETCH;
                        if (start) begin
                            count_q <= 32'd0;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        count_q <= 32'd0;
                    end
                end
                S_FETCH: begin
                    state_q <= past_end ? S_DONE : S_FWAIT;
                end
                S_FWAIT: begin
                    command_q <= mem_rdata[2:0];
                    state_q   <= S_CELL;
                end
                S_CELL: begin
                    state_q <= S_CWAIT;
                end
                S_CWAIT: begin
                    value_q    <= mem_rdata;
                    out_pend_q <= (command_q == c_cmd_out) && !search_active;
                    // A halt reached mid-search is just a skipped symbol, not a stop.
                    if ((command_q == c_cmd_halt) && !search_active) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    count_q <= count_q + 32'd1;
                    state_q <= S_POST;
                end
                S_POST: begin
                    if (out_pend_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= value_q;
                        state_q     <= S_OUT;
                    end else begin
                        state_q <= step_exit;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= step_exit;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM port decoded from the state register so reset drops a pending write at once.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        case (state_q)
            S_FETCH: mem_addr = prog_addr;
            S_CELL:  mem_addr = tape_addr;
            S_POST: begin
                if (write_trigger) begin
                    mem_we    = 1'b1;
                    mem_addr  = tape_addr;
                    mem_wdata = new_value;
                end
            end
            default: ;
        endcase
    end

    assign done            = (state_q == S_DONE);
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign instr_count     = count_q;
    assign run_trigger     = run_q;
    assign current_command = command_q;
    assign current_value   = value_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_bf_exec_sequencer.sv
// Bench for bf_exec_sequencer: behavioural RAM and bf_command_runner around the DUT,
// directed programs with hand-computed results.
`default_nettype none

module tb_bf_exec_sequencer;

    localparam logic [15:0] TB_PROG_LEN = 16'h0008;
    localparam logic [15:0] TB_TAPE     = 16'h8000;

    // Runner command encoding used by this bench's runner model.
    localparam logic [2:0] C_RIGHT = 3'd0;
    localparam logic [2:0] C_LEFT  = 3'd1;
    localparam logic [2:0] C_INC   = 3'd2;
    localparam logic [2:0] C_DEC   = 3'd3;
    localparam logic [2:0] C_OPEN  = 3'd4;
    localparam logic [2:0] C_CLOSE = 3'd5;
    localparam logic [2:0] C_OUT   = 3'd6;
    localparam logic [2:0] C_HALT  = 3'd7;

    logic        clk = 1'b0;
    logic        reset_trigger;
    logic        start;
`ifdef BF_SINGLE_STEP_EN
    logic        step_req;
`endif
    logic        done;
    logic        busy;
    logic [31:0] instr_count;
    logic        run_trigger;
    logic [2:0]  current_command;
    logic [7:0]  current_value;
    logic [15:0] command_addr;
    logic [15:0] cell_addr;
    logic [7:0]  new_value;
    logic        write_trigger;
    logic        search_active;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bf_exec_sequencer #(
        .ADDR_WIDTH (16),
        .PROG_BASE  (16'h0000),
        .TAPE_BASE  (TB_TAPE),
        .PROG_LEN   (TB_PROG_LEN)
    ) dut (
        .clk             (clk),
        .reset_trigger   (reset_trigger),
        .start           (start),
`ifdef BF_SINGLE_STEP_EN
        .step_req        (step_req),
`endif
        .done            (done),
        .busy            (busy),
        .instr_count     (instr_count),
        .run_trigger     (run_trigger),
        .current_command (current_command),
        .current_value   (current_value),
        .command_addr    (command_addr),
        .cell_addr       (cell_addr),
        .new_value       (new_value),
        .write_trigger   (write_trigger),
        .search_active   (search_active),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready)
    );

    // Single-port synchronous RAM with a bench-side load port.
    logic [7:0]  ram [0:65535];
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Runner model: brackets search one command per pulse; a search starts on its own
    // bracket and ends on the match with pc left there, so the match is re-executed.
    logic [15:0] r_pc;
    logic [15:0] r_ptr;
    logic [7:0]  r_nv;
    logic        r_wt;
    logic        r_srch;
    logic        r_back;
    int          r_depth;

    assign command_addr  = r_pc;
    assign cell_addr     = r_ptr;
    assign new_value     = r_nv;
    assign write_trigger = r_wt;
    assign search_active = r_srch;

    always @(posedge clk) begin
        if (reset_trigger) begin
            r_pc    <= 16'd0;
            r_ptr   <= 16'd0;
            r_nv    <= 8'd0;
            r_wt    <= 1'b0;
            r_srch  <= 1'b0;
            r_back  <= 1'b0;
            r_depth <= 0;
        end else begin
            r_wt <= 1'b0;
            if (run_trigger) begin
                if (r_srch && r_back) begin
                    if (current_command == C_CLOSE) begin
                        r_depth <= r_depth + 1;
                        r_pc    <= r_pc - 16'd1;
                    end else if (current_command == C_OPEN && r_depth == 1) begin
                        r_srch <= 1'b0;
                    end else if (current_command == C_OPEN) begin
                        r_depth <= r_depth - 1;
                        r_pc    <= r_pc - 16'd1;
                    end else begin
                        r_pc <= r_pc - 16'd1;
                    end
                end else if (r_srch) begin
                    if (current_command == C_OPEN) begin
                        r_depth <= r_depth + 1;
                        r_pc    <= r_pc + 16'd1;
                    end else if (current_command == C_CLOSE && r_depth == 1) begin
                        r_srch <= 1'b0;
                    end else if (current_command == C_CLOSE) begin
                        r_depth <= r_depth - 1;
                        r_pc    <= r_pc + 16'd1;
                    end else begin
                        r_pc <= r_pc + 16'd1;
                    end
                end else begin
                    r_pc <= r_pc + 16'd1;
                    case (current_command)
                        C_RIGHT: r_ptr <= r_ptr + 16'd1;
                        C_LEFT:  r_ptr <= r_ptr - 16'd1;
                        C_INC: begin
                            r_nv <= current_value + 8'd1;
                            r_wt <= 1'b1;
                        end
                        C_DEC: begin
                            r_nv <= current_value - 8'd1;
                            r_wt <= 1'b1;
                        end
                        C_OPEN: begin
                            if (current_value == 8'd0) begin
                                r_srch  <= 1'b1;
                                r_back  <= 1'b0;
                                r_depth <= 0;
                                r_pc    <= r_pc;
                            end
                        end
                        C_CLOSE: begin
                            if (current_value != 8'd0) begin
                                r_srch  <= 1'b1;
                                r_back  <= 1'b1;
                                r_depth <= 0;
                                r_pc    <= r_pc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Monitors: output transfers and any write into the program region.
    logic clr_mon;
    int   xfers;
    int   prog_writes;

    always @(posedge clk) begin
        if (clr_mon) begin
            xfers       <= 0;
            prog_writes <= 0;
        end else begin
            if (out_valid && out_ready) xfers <= xfers + 1;
            if (mem_we && mem_addr < TB_PROG_LEN) prog_writes <= prog_writes + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset_trigger = 1'b1;
        clr_mon       = 1'b1;
        tick();
        tick();
        reset_trigger = 1'b0;
        clr_mon       = 1'b0;
        tick();
    endtask

    // Program symbols: > < + - [ ] . and # for halt; unused slots are halts.
    task automatic load(input string prog);
        logic [2:0] c;
        for (int i = 0; i < 8; i++) begin
            c = C_HALT;
            if (i < prog.len()) begin
                case (prog[i])
                    ">":     c = C_RIGHT;
                    "<":     c = C_LEFT;
                    "+":     c = C_INC;
                    "-":     c = C_DEC;
                    "[":     c = C_OPEN;
                    "]":     c = C_CLOSE;
                    ".":     c = C_OUT;
                    default: c = C_HALT;
                endcase
            end
            poke(16'(i), {5'd0, c});
            poke(TB_TAPE + 16'(i), 8'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ticks until done (bounded); returns the number of ticks taken.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int m;
        reset_trigger = 1'b1;
        start         = 1'b0;
`ifdef BF_SINGLE_STEP_EN
        step_req      = 1'b0;
`endif
        out_ready     = 1'b0;
        ld_en         = 1'b0;
        ld_addr       = 16'd0;
        ld_data       = 8'd0;
        clr_mon       = 1'b1;
        tick();
        tick();

        check("rst_done",   32'(done), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_count",  instr_count, 32'd0);
        check("rst_run",    32'(run_trigger), 32'd0);
        check("rst_cmd",    32'(current_command), 32'd0);
        check("rst_val",    32'(current_value), 32'd0);
        check("rst_oval",   32'(out_valid), 32'd0);
        check("rst_odata",  32'(out_data), 32'd0);
        check("rst_we",     32'(mem_we), 32'd0);
        check("rst_addr",   32'(mem_addr), 32'd0);
        reset_trigger = 1'b0;
        clr_mon       = 1'b0;
        tick();

        // "+++.#" with the sink always ready.
        load("+++.#");
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("t1_out_lat", n, 24);
        check("t1_odata", 32'(out_data), 32'd3);
        wait_done(100, n);
        check("t1_halt_lat", n, 5);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_count", instr_count, 32'd4);
        check("t1_ram", 32'(ram[TB_TAPE]), 32'd3);
        check("t1_xfers", xfers, 1);

        // Same program, sink stalls for 10 cycles.
        load("+++.#");
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("t2_out_lat", n, 24);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", 32'(out_valid), 32'd1);
            check("t2_hold_data", 32'(out_data), 32'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_drop_valid", 32'(out_valid), 32'd0);
        wait_done(100, n);
        check("t2_done", 32'(done), 32'd1);
        check("t2_xfers", xfers, 1);
        check("t2_count", instr_count, 32'd4);

        // "++[-]#" with a stray start while busy.
        load("++[-]#");
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        pulse_start();
        wait_done(300, n);
        check("t3_latency", n + 11, 70);
        check("t3_done", 32'(done), 32'd1);
        check("t3_count", instr_count, 32'd11);
        check("t3_ram", 32'(ram[TB_TAPE]), 32'd0);
        check("t3_prog_writes", prog_writes, 0);

        // "+>+>+>+>" fills the program region; execution ends at PROG_LEN.
        load("+>+>+>+>");
        do_reset();
        pulse_start();
        wait_done(300, n);
        check("t4_latency", n, 49);
        check("t4_done", 32'(done), 32'd1);
        check("t4_count", instr_count, 32'd8);
        check("t4_ram0", 32'(ram[TB_TAPE]), 32'd1);
        check("t4_ram3", 32'(ram[TB_TAPE + 16'd3]), 32'd1);
        check("t4_ram4", 32'(ram[TB_TAPE + 16'd4]), 32'd0);
        // Restart from DONE: count clears, runner still past the end.
        pulse_start();
        check("t4_restart_busy", 32'(busy), 32'd1);
        check("t4_restart_count", instr_count, 32'd0);
        tick();
        check("t4_restart_done", 32'(done), 32'd1);

        // Reset asserted during POST of a "+" step.
        load("+#");
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("t5_post_we", 32'(mem_we), 32'd1);
        #1;
        reset_trigger = 1'b1;
        #1;
        check("t5_we", 32'(mem_we), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_addr", 32'(mem_addr), 32'd0);
        check("t5_wdata", 32'(mem_wdata), 32'd0);
        check("t5_count", instr_count, 32'd0);
        check("t5_cmd", 32'(current_command), 32'd0);
        tick();
        check("t5_ram", 32'(ram[TB_TAPE]), 32'd0);
        reset_trigger = 1'b0;
        tick();
        tick();
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_done", 32'(done), 32'd0);
        check("t5_ram_after", 32'(ram[TB_TAPE]), 32'd0);

`ifdef BF_SINGLE_STEP_EN
        // "++#" driven by three step_req pulses.
        load("++#");
        do_reset();
        for (int s = 0; s < 3; s++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            m = 0;
            while (busy && m < 50) begin
                tick();
                m++;
            end
            if (s < 2) begin
                check("t6_step_len", m, 6);
                check("t6_step_busy", 32'(busy), 32'd0);
                check("t6_step_done", 32'(done), 32'd0);
                check("t6_step_ram", 32'(ram[TB_TAPE]), 32'(s + 1));
            end else begin
                check("t6_final_done", 32'(done), 32'd1);
                check("t6_final_count", instr_count, 32'd2);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
